// File: rtl/store_pkg.sv
// Shared types and helpers for the store write path.
// Funct3 codes, queue entry layout, legality check and lane alignment.
package store_pkg;

  localparam int SU_ADDR_W = 13;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [SU_ADDR_W-1:0] waddr;
    logic [31:0]          wdata;
    logic [3:0]           be;
  } st_entry_t;

  function automatic logic st_legal(
    input logic [2:0] funct3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (funct3 == F3_SB): ok = 1'b1;
      (funct3 == F3_SH): ok = !a[0];
      (funct3 == F3_SW): ok = (a == 2'b00);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic st_entry_t align_store(
    input logic [2:0]  funct3,
    input logic [31:0] addr,
    input logic [31:0] data
  );
    st_entry_t e;
    e.waddr = addr[SU_ADDR_W+1:2];
    e.wdata = data;
    e.be    = 4'b1111;
    unique case (1'b1)
      (funct3 == F3_SB): begin
        e.wdata = {4{data[7:0]}};
        e.be    = 4'b0001 << addr[1:0];
      end
      (funct3 == F3_SH): begin
        e.wdata = {2{data[15:0]}};
        e.be    = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store queue; exposes head, count and an age-ordered entry view.
// Ports: i_push/i_entry, i_pop, o_head, o_count, o_ents (0=oldest), o_vld.
module store_fifo
  import store_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  st_entry_t             i_entry,
  input  logic                  i_pop,
  output st_entry_t             o_head,
  output logic [CW-1:0]         o_count,
  output st_entry_t [DEPTH-1:0] o_ents,
  output logic [DEPTH-1:0]      o_vld
);

  st_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload needs no reset: o_vld masks stale slots.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr] <= i_entry;
  end

  // Rotate so index 0 is the head; youngest valid entry is last.
  always_comb begin
    logic [PW-1:0] w_idx;
    w_idx  = '0;
    o_ents = '0;
    o_vld  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx     = r_rd + PW'(i);
      o_ents[i] = r_mem[w_idx];
      o_vld[i]  = (CW'(i) < r_cnt);
    end
  end

  assign o_head  = o_ents[0];
  assign o_count = r_cnt;

endmodule

// File: rtl/store_unit.sv
// RV32 store path: align, queue, drain to the data-memory write port,
// and flag loads hitting pending stores. Optional: STORE_FORWARD_EN.
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SU_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_funct3,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  output logic              st_error,
  input  logic              mem_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  output logic              ld_hazard,
  output logic [3:0]        ld_fwd_be,
  output logic [31:0]       ld_fwd_data,
  output logic              idle
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                  w_acc;
  logic                  w_ok;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  st_entry_t             w_ent;
  st_entry_t             w_head;
  logic [CW-1:0]         w_count;
  st_entry_t [DEPTH-1:0] w_ents;
  logic [DEPTH-1:0]      w_vld;

  logic                  r_err;
  logic                  r_we;
  st_entry_t             r_stage;

  assign st_ready = (w_count < CW'(DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_acc    = st_valid && st_ready;
  assign w_ok     = st_legal(st_funct3, st_addr[1:0]);
  assign w_push   = w_acc && w_ok;
  assign w_pop    = mem_grant && !w_empty;
  assign w_ent    = align_store(st_funct3, st_addr, st_data);

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_entry (w_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_ents  (w_ents),
    .o_vld   (w_vld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_stage <= '0;
    end else begin
      r_err <= w_acc && !w_ok;
      r_we  <= w_pop;
      if (w_pop) r_stage <= w_head;
    end
  end

  assign st_error  = r_err;
  assign mem_we    = r_we;
  assign mem_addr  = r_stage.waddr;
  assign mem_wdata = r_stage.wdata;
  assign mem_be    = r_stage.be;
  assign idle      = w_empty && !r_we;

  // Candidates in age order: write stage first, then queue head..tail.
  st_entry_t [DEPTH:0]   w_cand;
  logic [DEPTH:0]        w_cvld;
  logic [DEPTH:0]        w_match;
  logic [SU_ADDR_W-1:0]  w_ld_wa;
  logic                  w_unused_ld;

  assign w_ld_wa     = ld_addr[SU_ADDR_W+1:2];
  assign w_unused_ld = ^{ld_addr[31:SU_ADDR_W+2], ld_addr[1:0]};

  always_comb begin
    w_cand    = '0;
    w_cvld    = '0;
    w_cand[0] = r_stage;
    w_cvld[0] = r_we;
    for (int i = 0; i < DEPTH; i++) begin
      w_cand[i+1] = w_ents[i];
      w_cvld[i+1] = w_vld[i];
    end
  end

  always_comb begin
    w_match = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      w_match[i] = w_cvld[i] && (w_cand[i].waddr == w_ld_wa);
    end
  end

`ifdef STORE_FORWARD_EN
  logic [3:0]  w_fbe;
  logic [31:0] w_fdata;

  // Later (younger) candidates overwrite earlier bytes.
  always_comb begin
    w_fbe   = '0;
    w_fdata = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (w_match[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (w_cand[i].be[b]) begin
            w_fbe[b]          = 1'b1;
            w_fdata[8*b +: 8] = w_cand[i].wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign ld_hazard   = ld_valid && (|w_match) && (w_fbe != 4'b1111);
  assign ld_fwd_be   = w_fbe;
  assign ld_fwd_data = w_fdata;
`else
  logic w_unused_cand;

  assign w_unused_cand = ^w_cand;
  assign ld_hazard     = ld_valid && (|w_match);
  assign ld_fwd_be     = '0;
  assign ld_fwd_data   = '0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Randomized scoreboard bench for store_unit.
// Directed cases plus random traffic against a queue-based model.
module tb_store_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  st_funct3 = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_error;
  logic        mem_grant = 1'b0;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_data;
  logic        idle;

  always #5 clock = ~clock;

  store_unit #(.DEPTH(DEPTH), .ADDR_W(13)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_funct3   (st_funct3),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_error    (st_error),
    .mem_grant   (mem_grant),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hazard   (ld_hazard),
    .ld_fwd_be   (ld_fwd_be),
    .ld_fwd_data (ld_fwd_data),
    .idle        (idle)
  );

  typedef struct {
    int unsigned word;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  exp_t stage;
  bit   stage_v = 0;
  bit   exp_we = 0;
  bit   exp_err = 0;
  int   checks = 0;
  int   passed = 0;
  int   nwrites = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Reference: legality and lane placement from plain arithmetic.
  function automatic bit model_store(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
    output exp_t e);
    int off;
    off = int'(a % 4);
    e.word = (a / 4) % 8192;
    e.data = 0;
    e.be = 0;
    if (f3 == 3'd0) begin
      e.be = 4'(1 << off);
      e.data = d[7:0] * 32'h01010101;
      return 1;
    end
    if (f3 == 3'd1) begin
      if (off % 2 != 0) return 0;
      e.be = 4'(3 << off);
      e.data = d[15:0] * 32'h00010001;
      return 1;
    end
    if (f3 == 3'd2) begin
      if (off != 0) return 0;
      e.be = 4'hF;
      e.data = d;
      return 1;
    end
    return 0;
  endfunction

  task automatic chk_load(bit ldv, logic [31:0] la);
    exp_t p[$];
    logic [3:0]  fbe = 0;
    logic [31:0] fd = 0;
    bit hit = 0;
    bit hz;
    if (stage_v) p.push_back(stage);
    foreach (sb[i]) p.push_back(sb[i]);
    foreach (p[i]) begin
      if (p[i].word == (la / 4) % 8192) begin
        hit = 1;
        for (int b = 0; b < 4; b++) begin
          if (p[i].be[b]) begin
            fbe[b] = 1'b1;
            fd[8*b +: 8] = p[i].data[8*b +: 8];
          end
        end
      end
    end
`ifdef STORE_FORWARD_EN
    hz = ldv && hit && (fbe != 4'hF);
    chk("fwd_be", ld_fwd_be, fbe);
    chk("fwd_data", ld_fwd_data, fd);
`else
    hz = ldv && hit;
    chk("fwd_be", ld_fwd_be, 0);
    chk("fwd_data", ld_fwd_data, 0);
`endif
    chk("ld_hazard", ld_hazard, hz);
  endtask

  // One clock of stimulus, driven on the falling edge.
  task automatic cycle(bit st, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] d, bit g, bit ldv, logic [31:0] la);
    exp_t e;
    @(negedge clock);
    mem_grant = g;
    ld_valid = ldv;
    ld_addr = la;
    st_valid = 0;
    #1;
    chk("st_ready", st_ready, sb.size() < DEPTH);
    chk("idle", idle, sb.size() == 0 && !stage_v);
    chk_load(ldv, la);
    exp_we = g && sb.size() > 0;
    if (st) begin
      st_valid = 1;
      st_funct3 = f3;
      st_addr = a;
      st_data = d;
      if (sb.size() < DEPTH) begin
        if (model_store(f3, a, d, e)) sb.push_back(e);
        else exp_err = 1;
      end
    end
  endtask

  task automatic idle_cyc(bit g);
    cycle(0, 3'd0, 32'h0, 32'h0, g, 0, 32'h0);
  endtask

  task automatic do_reset(int n);
    @(negedge clock);
    reset_n = 0;
    st_valid = 0;
    mem_grant = 0;
    ld_valid = 0;
    sb.delete();
    stage_v = 0;
    exp_we = 0;
    exp_err = 0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", st_error, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    repeat (n) @(negedge clock);
    reset_n = 1;
  endtask

  task automatic store_chk(string nm, logic [2:0] f3, logic [31:0] a,
                           logic [31:0] d, logic [12:0] wa,
                           logic [31:0] wd, logic [3:0] be);
    cycle(1, f3, a, d, 1, 0, 32'h0);
    idle_cyc(1);
    chk({nm, "_we_early"}, mem_we, 0);
    idle_cyc(1);
    chk({nm, "_we"}, mem_we, 1);
    chk({nm, "_addr"}, mem_addr, wa);
    chk({nm, "_wdata"}, mem_wdata, wd);
    chk({nm, "_be"}, mem_be, be);
    idle_cyc(1);
    chk({nm, "_we_off"}, mem_we, 0);
  endtask

  task automatic err_chk(string nm, logic [2:0] f3, logic [31:0] a);
    cycle(1, f3, a, 32'h1234_5678, 1, 0, 32'h0);
    idle_cyc(1);
    chk({nm, "_err"}, st_error, 1);
    chk({nm, "_idle"}, idle, 1);
    idle_cyc(1);
    chk({nm, "_err_off"}, st_error, 0);
    chk({nm, "_no_we"}, mem_we, 0);
  endtask

  // Monitor: every cycle, check write strobe and error pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        chk("we_in_reset", mem_we, 0);
        stage_v = 0;
        exp_we = 0;
        exp_err = 0;
        continue;
      end
      chk("mem_we", mem_we, exp_we);
      chk("st_error", st_error, exp_err);
      exp_err = 0;
      if (mem_we) nwrites++;
      stage_v = 0;
      if (exp_we && sb.size() > 0) begin
        e = sb.pop_front();
        stage = e;
        stage_v = 1;
        if (mem_we) begin
          chk("wr_addr", mem_addr, e.word);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_be", mem_be, e.be);
        end
      end
      exp_we = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int r;
    logic [2:0] f3;
    logic [31:0] a;
    #1 reset_n = 0;
    do_reset(3);

    cycle(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h100);
    chk("init_idle", idle, 1);
    chk("init_we", mem_we, 0);
    chk("init_hz", ld_hazard, 0);

    store_chk("sw", 3'd2, 32'h100, 32'hDEADBEEF, 13'h40, 32'hDEADBEEF, 4'b1111);
    store_chk("sb", 3'd0, 32'h103, 32'h5A, 13'h40, 32'h5A5A5A5A, 4'b1000);
    store_chk("sh", 3'd1, 32'h102, 32'h1234, 13'h40, 32'h12341234, 4'b1100);

    err_chk("sh_mis", 3'd1, 32'h101);
    err_chk("sw_mis", 3'd2, 32'h102);
    err_chk("f3_bad", 3'd3, 32'h100);

    for (int i = 0; i < 4; i++)
      cycle(1, 3'd0, 32'h300 + i, 32'(i + 1), 0, 0, 32'h0);
    cycle(1, 3'd2, 32'h310, 32'h55, 0, 0, 32'h0);
    chk("full_ready", st_ready, 0);
    n0 = nwrites;
    for (int i = 0; i < 4; i++)
      cycle(i < 2, 3'd2, 32'h310, 32'h55, 1, 0, 32'h0);
    idle_cyc(0);
    chk("drain4", nwrites - n0, 4);
    repeat (3) idle_cyc(1);

    cycle(1, 3'd0, 32'h200, 32'h77, 0, 0, 32'h0);
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h201);
    chk("hz_hit", ld_hazard, 1);
`ifdef STORE_FORWARD_EN
    chk("hz_fbe1", ld_fwd_be, 4'b0001);
`endif
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h204);
    chk("hz_miss", ld_hazard, 0);
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h201);
    chk("hz_noload", ld_hazard, 0);
    cycle(1, 3'd2, 32'h200, 32'hCAFEF00D, 0, 1, 32'h201);
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h201);
`ifdef STORE_FORWARD_EN
    chk("hz_full_fbe", ld_fwd_be, 4'b1111);
    chk("hz_full", ld_hazard, 0);
`else
    chk("hz_two", ld_hazard, 1);
`endif
    repeat (4) idle_cyc(1);

    for (int i = 0; i < 3; i++)
      cycle(1, 3'd2, 32'h400 + 4 * i, 32'(i), 0, 0, 32'h0);
    idle_cyc(1);
    do_reset(2);
    n0 = nwrites;
    repeat (5) idle_cyc(1);
    chk("rst_nowr", nwrites - n0, 0);
    chk("rst_idle2", idle, 1);

    repeat (400) begin
      r = $urandom_range(0, 7);
      if (r < 3) f3 = 3'd0;
      else if (r < 5) f3 = 3'd1;
      else if (r < 7) f3 = 3'd2;
      else f3 = 3'($urandom_range(3, 7));
      a = ($urandom & 32'hFFFF8000) | (32'h200 + 32'($urandom_range(0, 15)));
      cycle($urandom_range(0, 1) == 1, f3, a, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            ($urandom & 32'hFFFF8000) | (32'h200 + 32'($urandom_range(0, 19))));
    end
    repeat (8) idle_cyc(1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
